// File: rtl/exhaustive_response_checker.sv
// Response-side checker for an exhaustive counting sweep: compares each DUT output
// against a golden truth table, counts mismatches, captures the first failing vector.
module exhaustive_response_checker #(
  parameter int                     N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'b1110_1000,
  parameter int                     ERR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_vec,
  input  logic              in_d,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              seq_err
);

  localparam int              NUM_VEC  = 1 << N_IN;
  localparam logic [N_IN:0]   LAST_IDX = (N_IN+1)'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t        state_reg;
  logic [N_IN:0] exp_idx_reg;

  logic             mismatch;
  logic             order_bad;
  logic [ERR_W-1:0] err_next;
  logic             seq_next;

  // Next values for the pair being accepted this cycle; used both for the
  // running flags and for the final pass verdict on the last pair.
  assign mismatch  = (in_d != EXPECTED[in_vec]);
  assign order_bad = ({1'b0, in_vec} != exp_idx_reg);
  assign err_next  = (mismatch && (err_count != ERR_MAX)) ? err_count + ERR_W'(1) : err_count;
  assign seq_next  = seq_err | order_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      exp_idx_reg      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      seq_err          <= 1'b0;
    end else if (start) begin
      // Arms from any state; a pair presented alongside start is discarded.
      state_reg        <= CHECK;
      exp_idx_reg      <= '0;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      seq_err          <= 1'b0;
    end else begin
      case (state_reg)
        CHECK: begin
          if (in_valid) begin
            err_count   <= err_next;
            seq_err     <= seq_next;
            exp_idx_reg <= exp_idx_reg + (N_IN+1)'(1);
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= in_vec;
            end
            if (exp_idx_reg == LAST_IDX) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_next == '0) && !seq_next;
            end
          end
        end
        IDLE, DONE: begin
          state_reg <= state_reg;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_response_checker.sv
// Directed bench: each sweep's expected verdict is modelled and queued when driven,
// then popped and compared when done rises.
module tb_exhaustive_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_vec = '0;
  logic       in_d = 1'b0;

  logic       busy, done, pass, first_fail_valid, seq_err;
  logic [3:0] err_count;
  logic [2:0] first_fail_vec;

  logic       busy2, done2, pass2, first_fail_valid2, seq_err2;
  logic [1:0] err_count2;
  logic [2:0] first_fail_vec2;

  always #5 clk = ~clk;

  exhaustive_response_checker #(.N_IN(3), .EXPECTED(8'b1110_1000), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec), .in_d(in_d),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec), .seq_err(seq_err)
  );

  exhaustive_response_checker #(.N_IN(3), .EXPECTED(8'b1110_1000), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec), .in_d(in_d),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_fail_valid(first_fail_valid2), .first_fail_vec(first_fail_vec2), .seq_err(seq_err2)
  );

  typedef struct {
    logic [3:0] err4;
    logic [1:0] err2;
    logic       ffv;
    logic [2:0] ffvec;
    logic       seq;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic [7:0] gold = 8'b1110_1000;  // 3-input majority
  int   vec_seq[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic dval(input int mode, input int v);
    logic g;
    g = gold[v];
    case (mode)
      1:       return 1'b0;   // stuck-at-0
      2:       return ~g;     // inverted
      default: return g;      // correct
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_ffv"}, first_fail_valid, 0);
    chk({tag, "_ffvec"}, first_fail_vec, 0);
    chk({tag, "_seq"}, seq_err, 0);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start_busy"}, busy, 1);
    chk({tag, "_start_done"}, done, 0);
    chk({tag, "_start_err"}, err_count, 0);
    chk({tag, "_start_seq"}, seq_err, 0);
  endtask

  task automatic drive_pair(input int v, input logic d);
    @(negedge clk);
    in_valid = 1'b1; in_vec = 3'(v); in_d = d;
    $display("pair vec=%0d d=%0b", v, d);
  endtask

  task automatic run_sweep(input string tag, input int mode, input bit gaps);
    exp_t e;
    int   v;
    logic d;
    e = '{err4: 4'd0, err2: 2'd0, ffv: 1'b0, ffvec: 3'd0, seq: 1'b0, pass: 1'b0};
    for (int i = 0; i < 8; i++) begin
      v = vec_seq[i];
      d = dval(mode, v);
      if (v != i) e.seq = 1'b1;
      if (d != gold[v]) begin
        if (e.err4 != 4'd15) e.err4 = e.err4 + 4'd1;
        if (e.err2 != 2'd3)  e.err2 = e.err2 + 2'd1;
        if (!e.ffv) begin e.ffv = 1'b1; e.ffvec = 3'(v); end
      end
    end
    e.pass = (e.err4 == 0) && !e.seq;
    sb.push_back(e);

    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      if (i == 7) begin
        @(negedge clk);
        chk({tag, "_done_early"}, done, 0);
        chk({tag, "_busy_mid"}, busy, 1);
        in_valid = 1'b1; in_vec = 3'(vec_seq[i]); in_d = dval(mode, vec_seq[i]);
        $display("pair vec=%0d d=%0b", vec_seq[i], in_d);
      end else begin
        drive_pair(vec_seq[i], dval(mode, vec_seq[i]));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, err_count, e.err4);
      chk({tag, "_err2"}, err_count2, e.err2);
      chk({tag, "_ffv"}, first_fail_valid, e.ffv);
      if (e.ffv) chk({tag, "_ffvec"}, first_fail_vec, e.ffvec);
      chk({tag, "_seq"}, seq_err, e.seq);
      chk({tag, "_pass"}, pass, e.pass);
      chk({tag, "_pass2"}, pass2, e.pass);
      $display("sweep %s err=%0d ffv=%0b ffvec=%0d seq=%0b pass=%0b",
               tag, err_count, first_fail_valid, first_fail_vec, seq_err, pass);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vec_seq[i] = i;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    // Correct DUT, then a wrapped pair in DONE must be ignored
    do_start("ok");
    run_sweep("ok", 0, 1'b0);
    drive_pair(0, ~gold[0]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("wrap_done", done, 1);
    chk("wrap_err", err_count, 0);
    chk("wrap_pass", pass, 1);

    // Stuck-at-0 DUT (re-armed from DONE)
    do_start("stuck0");
    run_sweep("stuck0", 1, 1'b0);

    // Inverted DUT: ERR_W=2 instance saturates at 3
    do_start("inv");
    run_sweep("inv", 2, 1'b0);

    // Correct DUT with gaps
    do_start("gaps");
    run_sweep("gaps", 0, 1'b1);

    // Out-of-order arrival
    vec_seq = '{0, 1, 2, 4, 3, 5, 6, 7};
    do_start("order");
    run_sweep("order", 0, 1'b0);
    for (int i = 0; i < 8; i++) vec_seq[i] = i;

    // Reset mid-sweep after vec 4, with vec 3 wrong
    do_start("rst");
    for (int i = 0; i < 5; i++) drive_pair(i, (i == 3) ? ~gold[i] : gold[i]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_err", err_count, 1);
    chk("rst_pre_ffv", first_fail_valid, 1);
    chk("rst_pre_ffvec", first_fail_vec, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rst_post");
    drive_pair(0, ~gold[0]);  // IDLE ignores pairs
    @(negedge clk);
    in_valid = 1'b0;
    check_idle_zero("rst_idle");
    do_start("rst_new");
    run_sweep("rst_new", 0, 1'b0);

    // start re-issued mid-sweep; the pair alongside start is discarded
    do_start("restart");
    for (int i = 0; i < 4; i++) drive_pair(i, (i == 3) ? ~gold[i] : gold[i]);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_vec = 3'd4; in_d = ~gold[4];
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("restart_err", err_count, 0);
    chk("restart_ffv", first_fail_valid, 0);
    chk("restart_busy", busy, 1);
    run_sweep("restart", 0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exhaustive_response_checker.md
Name: exhaustive_response_checker

Overview:
- Clocked checker that reads the outputs of a small N-input combinational DUT while a stimulus generator drives every input combination in counting order (0, 1, …, 2^N_IN−1).
- Each (vector, output) pair is compared against a golden truth table held in a parameter. The block counts mismatches, records the first failing vector and checks the vector ordering.
- It reports pass/fail once the full sweep completes. It sits on the response side of the bench, opposite the counting stimulus generator, and is synthesizable for on-board self-test.

Parameters:
- N_IN, 3, number of DUT inputs; the sweep length is 2^N_IN vectors.
- EXPECTED, 8'b1110_1000, golden truth table of width 2^N_IN; bit k is the expected DUT output for input vector k. The default is 3-input majority.
- ERR_W, 4, width of the mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a new sweep.
- in_valid  in  1  in_vec and in_d are valid this cycle.
- in_vec  in  N_IN  input vector currently applied to the DUT.
- in_d  in  1  DUT output sampled for in_vec.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next start or rst.
- pass  out  1  valid when done=1; 1 iff err_count==0 and seq_err==0.
- err_count  out  ERR_W  number of output mismatches, saturating.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.
- first_fail_vec  out  N_IN  first vector whose in_d mismatched.
- seq_err  out  1  sticky; a vector arrived out of counting order.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state=IDLE, expected index exp_idx=0.
  - busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, seq_err=0.
  - rst has priority over every other input. rst asserted mid-sweep aborts the sweep with no done.
- State machine: IDLE, CHECK, DONE.
  - IDLE: start=1 → CHECK. Clears exp_idx, err_count, first_fail_*, seq_err, done and pass. busy=1 from the next cycle.
  - CHECK: processes one pair per cycle with in_valid=1; cycles with in_valid=0 are ignored with no state change.
    - Compare: mismatch when in_d != EXPECTED[in_vec]. On a mismatch, err_count increments, saturating at 2^ERR_W−1.
    - First failure: on the first mismatch of the sweep, first_fail_vec ← in_vec and first_fail_valid ← 1. Later mismatches do not overwrite them.
    - Ordering: if in_vec != exp_idx, seq_err ← 1. The output comparison still uses in_vec, not exp_idx.
    - Index: exp_idx increments on every accepted pair.
    - Completion: when the accepted pair is the 2^N_IN-th of the sweep (exp_idx was 2^N_IN−1) → DONE. busy=0, done=1 and pass are registered on the same edge and include this final pair's result.
  - DONE: outputs hold. start=1 → re-arm as from IDLE (same clears, → CHECK).
- start in CHECK: restarts the sweep. Counters and flags are cleared; the in_valid pair in that same cycle is discarded.
- Latency:
  - All outputs are registered. err_count, first_fail_* and seq_err update on the edge after the offending in_valid cycle.
  - done rises on the edge after the last accepted pair.
- Width rules:
  - exp_idx is N_IN+1 bits so the terminal count is unambiguous.
  - The err_count increment never wraps.
  - EXPECTED is indexed with in_vec directly; all in_vec values are in range by construction.
- Wrap-around: a generator that wraps 7→0 after the sweep has no effect. In DONE, in_valid is ignored.

Test Plan:
- Correct DUT: rst, start, then 8 pairs vec=0..7 with in_d=EXPECTED[vec] on consecutive cycles → done=1 one cycle after vec 7, pass=1, err_count=0, first_fail_valid=0, seq_err=0.
- Stuck-at-0 DUT: in_d=0 for all vectors → err_count=4, first_fail_vec=3, pass=0.
- Inverted DUT with ERR_W=2 → 8 mismatches, err_count saturates at 3, first_fail_vec=0, pass=0.
- Gaps and ordering:
  - Correct outputs with in_valid low on alternate cycles → same result as the correct-DUT case; done follows vec 7.
  - Order 0,1,2,4,3,5,6,7 → seq_err=1, err_count=0, pass=0.
- Reset and restart:
  - rst pulsed after vec 4 with in_d wrong on vec 3 → all outputs return to 0 and state is IDLE; a new correct sweep gives pass=1.
  - start re-issued mid-sweep → counters cleared and completion requires a full 8 further pairs.
